// File: rtl/div_pipe.sv
// div_pipe: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Accepts one op from issue, computes one quotient bit per cycle, and holds
// the result until the writeback arbiter grants it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a new op from issue
// CALC  | 32 shift/subtract iterations on operand magnitudes
// FIX   | select quotient or remainder, apply sign, register result
// DONE  | result valid, waiting for writeback grant
module div_pipe #(
    parameter int XLEN      = 32,
    parameter int REG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ix_div_valid,
    output logic                 ix_div_ready,
    input  logic [REG_WIDTH-1:0] ix_div_rd,
    input  logic [XLEN-1:0]      ix_div_rs1,
    input  logic [XLEN-1:0]      ix_div_rs2,
    input  logic [1:0]           ix_div_op,
    output logic                 div_wb_valid,
    input  logic                 div_wb_ready,
    output logic [REG_WIDTH-1:0] div_wb_rd,
    output logic [XLEN-1:0]      div_wb_result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                 state;
    state_e                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [XLEN-1:0]        quo;
    logic [XLEN-1:0]        rem;
    logic [XLEN-1:0]        dvsr;
    logic [REG_WIDTH-1:0]   rd_q;
    logic                   op_rem_q;
    logic                   neg_q_q;
    logic                   neg_r_q;

    logic                   accept;
    logic                   is_signed;
    logic                   is_rem;
    logic                   rs1_neg;
    logic                   rs2_neg;
    logic [XLEN-1:0]        abs_rs1;
    logic [XLEN-1:0]        abs_rs2;
    logic                   div_zero;
    logic                   ovf;
    logic                   special;
    logic [XLEN-1:0]        special_result;
    logic [XLEN:0]          trial;
    logic [XLEN-1:0]        fix_mag;
    logic                   fix_neg;
    logic [XLEN-1:0]        fix_result;

    assign ix_div_ready = (state == IDLE);
    assign div_wb_valid = (state == DONE);
    assign accept       = ix_div_valid & ix_div_ready;

    // Operand decode: magnitudes, sign flags and the two early-out cases.
    // The magnitude of the most negative value is itself, read as unsigned.
    always_comb begin
        is_signed = ~ix_div_op[0];
        is_rem    = ix_div_op[1];
        rs1_neg   = is_signed & ix_div_rs1[XLEN-1];
        rs2_neg   = is_signed & ix_div_rs2[XLEN-1];
        abs_rs1   = rs1_neg ? (~ix_div_rs1 + XLEN'(1)) : ix_div_rs1;
        abs_rs2   = rs2_neg ? (~ix_div_rs2 + XLEN'(1)) : ix_div_rs2;
        div_zero  = (ix_div_rs2 == '0);
        ovf       = is_signed & (ix_div_rs1 == MIN_VAL) & (ix_div_rs2 == '1);
        special   = div_zero | ovf;
        if (div_zero) begin
            special_result = is_rem ? ix_div_rs1 : '1;
        end else begin
            special_result = is_rem ? '0 : MIN_VAL;
        end
    end

    // Restoring step and final sign fix-up.
    always_comb begin
        trial      = {rem, quo[XLEN-1]} - {1'b0, dvsr};
        fix_mag    = op_rem_q ? rem : quo;
        fix_neg    = op_rem_q ? neg_r_q : neg_q_q;
        fix_result = fix_neg ? (~fix_mag + XLEN'(1)) : fix_mag;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(XLEN - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (div_wb_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand latch, iteration registers and the result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= '0;
            quo           <= '0;
            rem           <= '0;
            dvsr          <= '0;
            rd_q          <= '0;
            op_rem_q      <= 1'b0;
            neg_q_q       <= 1'b0;
            neg_r_q       <= 1'b0;
            div_wb_rd     <= '0;
            div_wb_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rd_q     <= ix_div_rd;
                        op_rem_q <= is_rem;
                        neg_q_q  <= rs1_neg ^ rs2_neg;
                        neg_r_q  <= rs1_neg;
                        quo      <= abs_rs1;
                        rem      <= '0;
                        dvsr     <= abs_rs2;
                        cnt      <= '0;
                        if (special) begin
                            div_wb_rd     <= ix_div_rd;
                            div_wb_result <= special_result;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!trial[XLEN]) begin
                        rem <= trial[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= {rem[XLEN-2:0], quo[XLEN-1]};
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                end
                FIX: begin
                    div_wb_rd     <= rd_q;
                    div_wb_result <= fix_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_pipe.sv
// Testbench for div_pipe: directed vector table, handshake/reset sequences,
// and randomized ops against an arithmetic reference model.
module tb_div_pipe;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam logic [31:0] MIN32  = 32'h8000_0000;
    localparam int LAT_MAX = 60;

    logic        clk;
    logic        rst_n;
    logic        ix_div_valid;
    logic        ix_div_ready;
    logic [4:0]  ix_div_rd;
    logic [31:0] ix_div_rs1;
    logic [31:0] ix_div_rs2;
    logic [1:0]  ix_div_op;
    logic        div_wb_valid;
    logic        div_wb_ready;
    logic [4:0]  div_wb_rd;
    logic [31:0] div_wb_result;

    int total = 0;
    int bad   = 0;

    div_pipe #(.XLEN(32), .REG_WIDTH(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ix_div_valid  (ix_div_valid),
        .ix_div_ready  (ix_div_ready),
        .ix_div_rd     (ix_div_rd),
        .ix_div_rs1    (ix_div_rs1),
        .ix_div_rs2    (ix_div_rs2),
        .ix_div_op     (ix_div_op),
        .div_wb_valid  (div_wb_valid),
        .div_wb_ready  (div_wb_ready),
        .div_wb_rd     (div_wb_rd),
        .div_wb_result (div_wb_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference model: RISC-V division semantics in plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        longint r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            r  = op[1] ? (sa % sb) : (sa / sb);
            return 32'(r);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Edges after the accept edge until valid is observed (0 = valid at T+1).
    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 32'd0) return 0;
        if (!op[0] && a == MIN32 && b == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        int n;
        n = 0;
        while (!ix_div_ready && n < LAT_MAX) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ix_div_ready) begin
            bad++;
            total++;
            $display("FAIL issue_ready_timeout got=0 exp=1");
        end
        ix_div_valid = 1'b1;
        ix_div_op    = op;
        ix_div_rs1   = a;
        ix_div_rs2   = b;
        ix_div_rd    = rd;
        @(posedge clk);
        #1;
        ix_div_valid = 1'b0;
        ix_div_rs1   = $urandom;
        ix_div_rs2   = $urandom;
        ix_div_rd    = 5'($urandom);
        ix_div_op    = 2'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!div_wb_valid && lat < LAT_MAX) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!div_wb_valid) begin
            bad++;
            total++;
            $display("FAIL wb_valid_timeout got=0 exp=1");
        end
    endtask

    task automatic ack();
        div_wb_ready = 1'b1;
        @(posedge clk);
        #1;
        div_wb_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] held;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          5'd6,  32'd2,          33};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,          5'd7,  32'hFFFF_FFF2,  33};
        vecs[3]  = '{OP_REM,  32'hFFFF_FF9C,  32'd7,          5'd8,  32'hFFFF_FFFE,  33};
        vecs[4]  = '{OP_REM,  32'd100,        32'hFFFF_FFF9,  5'd9,  32'd2,          33};
        vecs[5]  = '{OP_DIV,  32'h0000_1234,  32'd0,          5'd10, 32'hFFFF_FFFF,  0};
        vecs[6]  = '{OP_REMU, 32'h0000_1234,  32'd0,          5'd11, 32'h0000_1234,  0};
        vecs[7]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  0};
        vecs[8]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          0};
        vecs[9]  = '{OP_DIVU, 32'h8000_0000,  32'd2,          5'd14, 32'h4000_0000,  33};
        vecs[10] = '{OP_DIV,  32'h8000_0000,  32'd2,          5'd15, 32'hC000_0000,  33};
        vecs[11] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF,  33};

        rst_n        = 1'b0;
        ix_div_valid = 1'b0;
        ix_div_rd    = '0;
        ix_div_rs1   = '0;
        ix_div_rs2   = '0;
        ix_div_op    = '0;
        div_wb_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(div_wb_valid), 32'd0);
        check("reset_rd", 32'(div_wb_rd), 32'd0);
        check("reset_result", div_wb_result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ix_ready", 32'(ix_div_ready), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
            wait_valid(lat);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_rd", i), 32'(div_wb_rd), 32'(vecs[i].rd));
            check($sformatf("vec%0d_result", i), div_wb_result, vecs[i].exp);
            ack();
        end

        // Writeback stall with a competing op held on the issue port.
        issue(OP_DIVU, 32'd1000, 32'd7, 5'd9);
        wait_valid(lat);
        check("stall_lat", 32'(lat), 32'd33);
        check("stall_result", div_wb_result, 32'd142);
        held = div_wb_result;
        ix_div_valid = 1'b1;
        ix_div_op    = OP_DIVU;
        ix_div_rs1   = 32'd50;
        ix_div_rs2   = 32'd5;
        ix_div_rd    = 5'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_valid", i), 32'(div_wb_valid), 32'd1);
            check($sformatf("stall%0d_result", i), div_wb_result, held);
            check($sformatf("stall%0d_rd", i), 32'(div_wb_rd), 32'd9);
            check($sformatf("stall%0d_ix_ready", i), 32'(ix_div_ready), 32'd0);
        end
        ix_div_valid = 1'b0;
        ack();
        check("post_ack_ix_ready", 32'(ix_div_ready), 32'd1);
        check("post_ack_valid", 32'(div_wb_valid), 32'd0);
        issue(OP_DIVU, 32'd77, 32'd7, 5'd3);
        check("b2b_accepted", 32'(ix_div_ready), 32'd0);
        wait_valid(lat);
        check("b2b_lat", 32'(lat), 32'd33);
        check("b2b_result", div_wb_result, 32'd11);
        check("b2b_rd", 32'(div_wb_rd), 32'd3);
        ack();

        // Reset in CALC cycle 15 discards the op.
        issue(OP_DIVU, 32'hDEAD_BEEF, 32'd3, 5'd7);
        repeat (14) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(ix_div_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_valid", 32'(div_wb_valid), 32'd0);
        check("midrst_rd", 32'(div_wb_rd), 32'd0);
        check("midrst_result", div_wb_result, 32'd0);
        check("midrst_ix_ready", 32'(ix_div_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (div_wb_valid) seen++;
        end
        check("midrst_no_wb", 32'(seen), 32'd0);
        issue(OP_DIVU, 32'd9, 32'd3, 5'd4);
        wait_valid(lat);
        check("after_rst_lat", 32'(lat), 32'd33);
        check("after_rst_result", div_wb_result, 32'd3);
        ack();

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       a = MIN32;
                1:       a = 32'($urandom_range(0, 100));
                default: a = $urandom;
            endcase
            rd = 5'($urandom);
            issue(op, a, b, rd);
            wait_valid(lat);
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ref_lat(op, a, b)));
            check($sformatf("rnd%0d_rd", i), 32'(div_wb_rd), 32'(rd));
            check($sformatf("rnd%0d_result op=%0d a=%h b=%h", i, op, a, b),
                  div_wb_result, ref_result(op, a, b));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            ack();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
